rrc_tx_sched: RTL and testbench

Symbol scheduler that sits in front of the RRC pulse-shaping FIR in the BPSK transmitter. It accepts bits over a valid/ready handshake and maps each to a signed ±1 FIR input. It zero-stuffs to SPS samples per symbol. At end of burst it drains the filter tail with zeros. It also detects and flags symbol underflow mid-burst.

---
 rtl/rrc_tx_sched_if.sv | 11 +
 rtl/rrc_tx_sched.sv | 178 +++++++++++++++++
 tb/tb_rrc_tx_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rrc_tx_sched_if.sv
// Symbol handshake between the bit source and the RRC transmit scheduler.
// The source drives valid/data/last and the scheduler answers with ready.
interface rrc_tx_sched_if;
    logic sym_valid;
    logic sym_data;
    logic sym_last;
    logic sym_ready;

    modport master (output sym_valid, output sym_data, output sym_last, input sym_ready);
    modport slave  (input sym_valid, input sym_data, input sym_last, output sym_ready);
endinterface

// File: rtl/rrc_tx_sched.sv
// BPSK symbol scheduler in front of the RRC FIR: maps bits to +/-1, zero-stuffs to SPS, flushes the tail.
// Optional macro RRC_TX_SCHED_STATS_EN adds saturating sym_count/underflow_count outputs.
module rrc_tx_sched #(
    parameter int SPS         = 4,
    parameter int NUM_TAPS    = 16,
    parameter int INPUT_WIDTH = 2
`ifdef RRC_TX_SCHED_STATS_EN
    ,
    parameter int CNT_WIDTH   = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    rrc_tx_sched_if.slave                 sym,
    output logic signed [INPUT_WIDTH-1:0] fir_din,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          underflow,
    input  logic                          clr_underflow
`ifdef RRC_TX_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]          sym_count,
    output logic [CNT_WIDTH-1:0]          underflow_count
`endif
);

    localparam int PH_W = $clog2(SPS);
    localparam int FL_W = $clog2(NUM_TAPS + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(NUM_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_r;
    logic [PH_W-1:0]   phase_r;
    logic [FL_W-1:0]   flush_cnt_r;
    logic              last_seen_r;
    logic              ready_s;
    logic              xfer_s;
    logic              underflow_set_s;

    function automatic logic [INPUT_WIDTH-1:0] sym_map(input logic bit_in);
        return bit_in ? {INPUT_WIDTH{1'b1}} : {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Ready decode: IDLE follows enable, RUN only at the last phase of a non-final symbol.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  ready_s = enable;
            ST_RUN:   ready_s = (phase_r == PH_LAST) && !last_seen_r && enable;
            ST_FLUSH: ready_s = 1'b0;
            default:  ready_s = 1'b0;
        endcase
        xfer_s          = sym.sym_valid && ready_s;
        // A boundary that was ready for a symbol but got none is an underflow.
        underflow_set_s = (state_r == ST_RUN) && ready_s && !sym.sym_valid;
    end

    assign sym.sym_ready = ready_s;

    // Main scheduler FSM with registered sample outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            phase_r      <= {PH_W{1'b0}};
            flush_cnt_r  <= {FL_W{1'b0}};
            last_seen_r  <= 1'b0;
            fir_din      <= {INPUT_WIDTH{1'b0}};
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fir_din      <= {INPUT_WIDTH{1'b0}};
                    sample_valid <= 1'b0;
                    busy         <= 1'b0;
                    if (xfer_s) begin
                        state_r      <= ST_RUN;
                        phase_r      <= {PH_W{1'b0}};
                        fir_din      <= sym_map(sym.sym_data);
                        sample_valid <= 1'b1;
                        busy         <= 1'b1;
                        last_seen_r  <= sym.sym_last;
                    end
                end
                ST_RUN: begin
                    sample_valid <= 1'b1;
                    busy         <= 1'b1;
                    if (phase_r != PH_LAST) begin
                        phase_r <= phase_r + PH_W'(1);
                        fir_din <= {INPUT_WIDTH{1'b0}};
                    end else if (xfer_s) begin
                        phase_r     <= {PH_W{1'b0}};
                        fir_din     <= sym_map(sym.sym_data);
                        last_seen_r <= sym.sym_last;
                    end else if (!last_seen_r && enable) begin
                        phase_r <= {PH_W{1'b0}};
                        fir_din <= {INPUT_WIDTH{1'b0}};
                    end else begin
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= {FL_W{1'b0}};
                        fir_din     <= {INPUT_WIDTH{1'b0}};
                    end
                end
                ST_FLUSH: begin
                    fir_din <= {INPUT_WIDTH{1'b0}};
                    if (flush_cnt_r == FL_LAST) begin
                        state_r      <= ST_IDLE;
                        phase_r      <= {PH_W{1'b0}};
                        sample_valid <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        flush_cnt_r  <= flush_cnt_r + FL_W'(1);
                        sample_valid <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    phase_r      <= {PH_W{1'b0}};
                    flush_cnt_r  <= {FL_W{1'b0}};
                    fir_din      <= {INPUT_WIDTH{1'b0}};
                    sample_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (underflow_set_s) begin
            underflow <= 1'b1;
        end else if (clr_underflow) begin
            underflow <= 1'b0;
        end else begin
            underflow <= underflow;
        end
    end

`ifdef RRC_TX_SCHED_STATS_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Saturating statistics; clear and increment together leaves a count of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count       <= {CNT_WIDTH{1'b0}};
            underflow_count <= {CNT_WIDTH{1'b0}};
        end else begin
            if (xfer_s) begin
                sym_count <= sat_inc(clr_underflow ? {CNT_WIDTH{1'b0}} : sym_count);
            end else if (clr_underflow) begin
                sym_count <= {CNT_WIDTH{1'b0}};
            end else begin
                sym_count <= sym_count;
            end
            if (underflow_set_s) begin
                underflow_count <= sat_inc(clr_underflow ? {CNT_WIDTH{1'b0}} : underflow_count);
            end else if (clr_underflow) begin
                underflow_count <= {CNT_WIDTH{1'b0}};
            end else begin
                underflow_count <= underflow_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rrc_tx_sched.sv
// Directed bench for rrc_tx_sched: outputs sampled on the falling edge against hand-computed sequences.
// Counter checks are compiled in only when RRC_TX_SCHED_STATS_EN is defined.
module tb_rrc_tx_sched;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clr_underflow = 1'b0;
    logic [IW-1:0] fir_din;
    logic          sample_valid;
    logic          busy;
    logic          underflow;
    int            checks = 0;
    int            failures = 0;
`ifdef RRC_TX_SCHED_STATS_EN
    logic [15:0]   sym_count;
    logic [15:0]   underflow_count;
`endif

    rrc_tx_sched_if sif ();

    rrc_tx_sched #(.SPS(4), .NUM_TAPS(16), .INPUT_WIDTH(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sym           (sif),
        .fir_din       (fir_din),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .underflow     (underflow),
        .clr_underflow (clr_underflow)
`ifdef RRC_TX_SCHED_STATS_EN
        ,
        .sym_count       (sym_count),
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sym_drive(input logic v, input logic d, input logic l);
        sif.sym_valid = v;
        sif.sym_data  = d;
        sif.sym_last  = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sym_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_fir", fir_din, 2'b00);
        check("rst_sv", sample_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_uf", underflow, 1'b0);
        check("rst_ready", sif.sym_ready, 1'b0);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("idle_ready", sif.sym_ready, 1'b1);

        // Single symbol, last: 01, three zeros, 17 flush zeros, idle at k=22.
        sym_drive(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check($sformatf("t1_fir_k%0d", k), fir_din, (k == 1) ? 2'b01 : 2'b00);
            check($sformatf("t1_sv_k%0d", k), sample_valid, (k <= 21));
            check($sformatf("t1_busy_k%0d", k), busy, (k <= 21));
            if (k == 1) sym_drive(1'b0, 1'b0, 1'b0);
        end

        // Burst 0,1,1 held valid, last on the third symbol.
        sym_drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("t2_fir_k%0d", k), fir_din,
                  (k == 1) ? 2'b01 : ((k == 5 || k == 9) ? 2'b11 : 2'b00));
            check($sformatf("t2_sv_k%0d", k), sample_valid, (k <= 29));
            if (k <= 12) check($sformatf("t2_rdy_k%0d", k), sif.sym_ready, (k == 4 || k == 8));
            if (k == 1) sym_drive(1'b1, 1'b1, 1'b0);
            if (k == 5) sym_drive(1'b1, 1'b1, 1'b1);
            if (k == 9) sym_drive(1'b0, 1'b0, 1'b0);
        end

        // Missing symbol at the second boundary, then a normal last symbol; clear flag at k=10.
        sym_drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("t3_fir_k%0d", k), fir_din,
                  (k == 1) ? 2'b01 : ((k == 9) ? 2'b11 : 2'b00));
            check($sformatf("t3_uf_k%0d", k), underflow, (k >= 5 && k <= 10));
            check($sformatf("t3_busy_k%0d", k), busy, (k <= 29));
            if (k == 4 || k == 8) check($sformatf("t3_rdy_k%0d", k), sif.sym_ready, 1'b1);
            clr_underflow = (k == 10);
            if (k == 1) sym_drive(1'b0, 1'b0, 1'b0);
            if (k == 5) sym_drive(1'b1, 1'b1, 1'b1);
            if (k == 9) sym_drive(1'b0, 1'b0, 1'b0);
        end

        // Enable dropped mid-symbol: flush at the next boundary, ready held low throughout.
        sym_drive(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check($sformatf("t4_fir_k%0d", k), fir_din, (k == 1) ? 2'b11 : 2'b00);
            check($sformatf("t4_sv_k%0d", k), sample_valid, (k <= 21));
            check($sformatf("t4_rdy_k%0d", k), sif.sym_ready, (k == 22));
            check($sformatf("t4_uf_k%0d", k), underflow, 1'b0);
            if (k == 1) sym_drive(1'b1, 1'b0, 1'b0);
            if (k == 2) enable = 1'b0;
            if (k == 10) enable = 1'b1;
            if (k == 21) sym_drive(1'b0, 1'b0, 1'b0);
        end

        // Underflow, then reset during phase 2; a fresh burst follows cleanly.
        sym_drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k <= 7) check($sformatf("t5_uf_k%0d", k), underflow, (k >= 5));
            if (k == 8) begin
                check("t5_rst_fir", fir_din, 2'b00);
                check("t5_rst_sv", sample_valid, 1'b0);
                check("t5_rst_busy", busy, 1'b0);
                check("t5_rst_uf", underflow, 1'b0);
            end
            if (k >= 9) begin
                check($sformatf("t5_fir_k%0d", k), fir_din, (k == 9) ? 2'b11 : 2'b00);
                check($sformatf("t5_busy_k%0d", k), busy, (k <= 29));
            end
            if (k == 1) sym_drive(1'b0, 1'b0, 1'b0);
            if (k == 7) rst = 1'b1;
            if (k == 8) begin
                rst = 1'b0;
                sym_drive(1'b1, 1'b1, 1'b1);
            end
            if (k == 9) sym_drive(1'b0, 1'b0, 1'b0);
        end

`ifdef RRC_TX_SCHED_STATS_EN
        // Clear counters, then five symbols with two underflows.
        clr_underflow = 1'b1;
        @(negedge clk);
        clr_underflow = 1'b0;
        check("st_clr_sym", sym_count, 16'd0);
        sym_drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k == 25) begin
                check("st_sym_count", sym_count, 16'd5);
                check("st_uf_count", underflow_count, 16'd2);
                check("st_uf", underflow, 1'b1);
            end
            sym_drive((k == 4 || k == 12 || k == 20 || k == 24), 1'b0, (k == 24));
        end
        check("st_idle", busy, 1'b0);

        // Underflow coinciding with clear: flag stays set, count restarts at one.
        sym_drive(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check("st_sim_uf", underflow, 1'b1);
                check("st_sim_uf_count", underflow_count, 16'd1);
                check("st_sim_sym_count", sym_count, 16'd0);
            end
            if (k == 1) sym_drive(1'b0, 1'b0, 1'b0);
            clr_underflow = (k == 4);
            if (k == 5) enable = 1'b0;
        end
        check("st_sim_idle", busy, 1'b0);
        enable = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
